// File: rtl/n64_pkg.sv
// ============================================================================
// Module      : n64_pkg
// Description : Shared N64 line timing constants, FSM state type and helpers
//               for the N64 asynchronous bit recovery block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package n64_pkg;

  // N64 bit timing in microseconds
  localparam int BIT_US      = 4;
  localparam int ZERO_LOW_US = 3;
  localparam int ONE_LOW_US  = 1;

  // Nominal 4 MHz sample clock
  localparam int DEFAULT_CLKS_PER_US = 4;

  // Bit-recovery FSM states
  typedef enum logic [1:0] {
    N64_IDLE      = 2'd0,
    N64_MEASURE   = 2'd1,
    N64_STROBE    = 2'd2,
    N64_WAIT_HIGH = 2'd3
  } n64_state_e;

  // Three-input majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : n64_pkg

`default_nettype wire

// File: rtl/n64_line_sync.sv
// ============================================================================
// Module      : n64_line_sync
// Description : Synchronizes the asynchronous N64 data line, optionally
//               majority-filters it, and flags falling edges.
//               Optional feature macro: GLITCH_FILTER_EN (3-sample majority
//               vote, one extra cycle of latency, rejects 1-cycle pulses).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64_line_sync
  import n64_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic data_i,
  output logic d_s_o,
  output logic fall_o
);

  // Flops reset high so the idle-high line never looks like a falling edge
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line_w;

  // Shift the raw line through the synchronizer chain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
    end
  end

`ifdef GLITCH_FILTER_EN
  // Two older synchronized samples kept for the majority vote
  logic [1:0] hist_q;

  // Record the last two synchronized samples
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign line_w = maj3(sync_q[SYNC_STAGES-1], hist_q[0], hist_q[1]);
`else
  assign line_w = sync_q[SYNC_STAGES-1];
`endif

  // Previous line sample for edge detection; runs regardless of enable
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= line_w;
    end
  end

  assign d_s_o  = line_w;
  assign fall_o = prev_q & ~line_w;

endmodule : n64_line_sync

`default_nettype wire

// File: rtl/n64_async_to_sync.sv
// ============================================================================
// Module      : n64_async_to_sync
// Description : Recovers bits from the single-wire N64 line. Each low pulse
//               is timed from its falling edge; the line is sampled at the
//               bit midpoint and presented on derived_signal with a strobe
//               on derived_clk.
//               Optional feature macro: GLITCH_FILTER_EN (in n64_line_sync).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64_async_to_sync
  import n64_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int CLKS_PER_US   = DEFAULT_CLKS_PER_US,
  parameter int SAMPLE_POINT  = (BIT_US / 2) * CLKS_PER_US,
  parameter int STROBE_CYCLES = CLKS_PER_US,
  parameter int IDLE_TIMEOUT  = 6 * CLKS_PER_US
) (
  input  logic sample_clk,
  input  logic reset,
  input  logic enable,
  input  logic data,
  output logic derived_signal,
  output logic derived_clk
);

  // State encodings taken from the shared enum
  localparam logic [1:0] S_IDLE      = 2'(N64_IDLE);
  localparam logic [1:0] S_MEASURE   = 2'(N64_MEASURE);
  localparam logic [1:0] S_STROBE    = 2'(N64_STROBE);
  localparam logic [1:0] S_WAIT_HIGH = 2'(N64_WAIT_HIGH);

  // One counter covers the measurement, the strobe and the low-line timeout
  localparam int CNT_MAX = (SAMPLE_POINT > IDLE_TIMEOUT) ? SAMPLE_POINT : IDLE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TMO    = CNT_W'(IDLE_TIMEOUT);

  logic             d_s;
  logic             fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dsig_q, dsig_d;
  logic             dclk_q, dclk_d;

  n64_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_i  (sample_clk),
    .rst_ni (reset),
    .data_i (data),
    .d_s_o  (d_s),
    .fall_o (fall)
  );

  // Next-state logic: time the low pulse, sample at midpoint, emit strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dsig_d  = dsig_q;
    dclk_d  = dclk_q;

    if (!enable) begin
      // Abandon any bit in flight; the decoded value is kept
      state_d = S_IDLE;
      cnt_d   = '0;
      dclk_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_d = S_MEASURE;
            cnt_d   = CNT_ONE;
          end
        end

        S_MEASURE: begin
          if (cnt_q == CNT_SAMPLE) begin
            dsig_d  = d_s;
            dclk_d  = 1'b1;
            state_d = S_STROBE;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_STROBE: begin
          // From here on the counter measures cycles since the sample point
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_STROBE) begin
            dclk_d = 1'b0;
            if (d_s) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_WAIT_HIGH;
            end
          end
        end

        S_WAIT_HIGH: begin
          // A stuck-low line drops back to IDLE; only a new edge rearms
          if (d_s || (cnt_q >= CNT_TMO)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dclk_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge sample_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dsig_q  <= 1'b1;
      dclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dsig_q  <= dsig_d;
      dclk_q  <= dclk_d;
    end
  end

  assign derived_signal = dsig_q;
  assign derived_clk    = dclk_q;

endmodule : n64_async_to_sync

`default_nettype wire

// File: tb/tb_n64_async_to_sync.sv
// ============================================================================
// Module      : tb_n64_async_to_sync
// Description : Self-checking bench for n64_async_to_sync. Stimulus pushes
//               expected strobes (cycle, value) into a scoreboard; a monitor
//               pops and compares on every derived_clk rising edge.
//               Honours GLITCH_FILTER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_n64_async_to_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int CLKS_PER_US   = 4;
  localparam int SAMPLE_POINT  = 2 * CLKS_PER_US;
  localparam int STROBE_CYCLES = CLKS_PER_US;
  localparam int IDLE_TIMEOUT  = 6 * CLKS_PER_US;

`ifdef GLITCH_FILTER_EN
  localparam int LAT       = SYNC_STAGES + SAMPLE_POINT + 1;
  localparam int MIN_PULSE = 2;
`else
  localparam int LAT       = SYNC_STAGES + SAMPLE_POINT;
  localparam int MIN_PULSE = 1;
`endif

  logic sample_clk = 1'b0;
  logic reset      = 1'b0;
  logic enable     = 1'b0;
  logic data       = 1'b1;
  logic derived_signal;
  logic derived_clk;

  n64_async_to_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .CLKS_PER_US   (CLKS_PER_US),
    .SAMPLE_POINT  (SAMPLE_POINT),
    .STROBE_CYCLES (STROBE_CYCLES),
    .IDLE_TIMEOUT  (IDLE_TIMEOUT)
  ) dut (
    .sample_clk     (sample_clk),
    .reset          (reset),
    .enable         (enable),
    .data           (data),
    .derived_signal (derived_signal),
    .derived_clk    (derived_clk)
  );

  always #5 sample_clk = ~sample_clk;

  int cyc = 0;
  always @(posedge sample_clk) cyc <= cyc + 1;

  typedef struct {
    int   cycle;
    logic val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   strobes  = 0;
  int   pushed   = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference rule: the decoded bit is the line level at the bit midpoint,
  // i.e. low only when the low phase outlasts the sample point.
  function automatic logic model_bit(input int low);
    return (low > SAMPLE_POINT) ? 1'b0 : 1'b1;
  endfunction

  // Drive one low pulse followed by high; caller sits on a negedge.
  task automatic send(input int low, input int total);
    exp_t e;
    data = 1'b0;
    if (low >= MIN_PULSE) begin
      e.cycle = cyc + 1 + LAT;
      e.val   = model_bit(low);
      sb.push_back(e);
      pushed++;
    end
    repeat (low) @(negedge sample_clk);
    data = 1'b1;
    repeat (total - low) @(negedge sample_clk);
  endtask

  // Monitor: compare each strobe against the scoreboard and check its width
  logic mon_prev = 1'b0;
  int   hi_len   = 0;
  always @(negedge sample_clk) begin
    if (derived_clk === 1'b1 && mon_prev === 1'b0) begin
      strobes++;
      hi_len = 1;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", cyc, mon_e.cycle);
        check("strobe_value", int'(derived_signal), int'(mon_e.val));
      end
    end else if (derived_clk === 1'b1) begin
      hi_len++;
    end else if (mon_prev === 1'b1) begin
      check("strobe_width", hi_len, STROBE_CYCLES);
    end
    mon_prev = derived_clk;
  end

  // Watchdog so the run always ends
  initial begin
    #(10 * 20000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] byte_v;
    int         lo;

    // Reset held with the line low: outputs must sit at reset values
    reset = 1'b0;
    data  = 1'b0;
    repeat (5) @(negedge sample_clk);
    check("reset_derived_signal", int'(derived_signal), 1);
    check("reset_derived_clk", int'(derived_clk), 0);

    // Release reset with an idle-high line: no strobe expected
    data = 1'b1;
    @(negedge sample_clk);
    reset  = 1'b1;
    enable = 1'b1;
    repeat (20) @(negedge sample_clk);
    check("post_reset_no_strobe", strobes, 0);

    // Single "0" and "1" bits
    send(12, 16);
    send(4, 16);
    repeat (8) @(negedge sample_clk);

    // Byte 0x01 MSB first, then the stop bit, back-to-back
    byte_v = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      if (byte_v[i]) send(4, 16);
      else           send(12, 16);
    end
    send(4, 16);
    repeat (8) @(negedge sample_clk);

    // Line stuck low: one "0" strobe, then timeout back to IDLE
    send(60, 90);

    // Enable dropped mid-bit: no strobe for it, next bit decodes
    data = 1'b0;
    repeat (3) @(negedge sample_clk);
    enable = 1'b0;
    repeat (4) @(negedge sample_clk);
    enable = 1'b1;
    repeat (5) @(negedge sample_clk);
    data = 1'b1;
    repeat (4) @(negedge sample_clk);
    send(4, 16);

    // Reset pulse mid-bit: the interrupted bit produces no strobe
    data = 1'b0;
    repeat (3) @(negedge sample_clk);
    data = 1'b1;
    repeat (2) @(negedge sample_clk);
    reset = 1'b0;
    @(negedge sample_clk);
    reset = 1'b1;
    repeat (16) @(negedge sample_clk);

    // Single-cycle low glitch (decodes as "1" unless filtered out)
    send(1, 17);
    send(12, 16);

    // Randomized stream of ones and zeros with varying bit spacing
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) lo = $urandom_range(1, 5);
      else                           lo = $urandom_range(10, 13);
      send(lo, 16 + $urandom_range(0, 4));
    end

    repeat (40) @(negedge sample_clk);
    check("scoreboard_empty", sb.size(), 0);
    check("strobe_count", strobes, pushed);
    check("idle_derived_clk", int'(derived_clk), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_n64_async_to_sync

`default_nettype wire
